encoder_emulator: RTL and testbench

- Generates the encoder pulse stream that fCounter measures: a square wave on data whose edge rate corresponds to a commanded RPM.
- Serves as a stimulus source for closed-loop bench and board tests of the speed-measurement path.
- Each data transition represents 1/PPR revolution, the same convention fCounter decodes: 1000 rpm at PPR=10 and 100 ns clk gives 6 ms high and 6 ms low.
- An RPM command enters through a valid/ready handshake. An iterative divider converts it to a half-period in clocks, and the new rate takes effect glitch-free at the next data edge.

---
 rtl/encoder_emu_pkg.sv | 17 +
 rtl/encoder_emulator_if.sv | 11 +
 rtl/div_u32_iter.sv | 74 +++++++
 rtl/encoder_emulator.sv | 146 ++++++++++++++
 tb/tb_encoder_emulator.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/encoder_emu_pkg.sv
// Shared types, constants and the clocks-per-edge helper for the encoder emulator.
package encoder_emu_pkg;

    localparam int DIV_W  = 32;
    localparam int ITER_W = $clog2(DIV_W);

    typedef enum logic [1:0] {IDLE, DIV, DONE} emu_state_t;

    // One data edge per 1/PPR revolution: K = 60 s * 1e9 ns / (PPR * clk period in ns).
    function automatic logic [63:0] calc_k(input logic [63:0] clk_period_ns,
                                           input logic [63:0] ppr);
        logic [63:0] den;
        den = clk_period_ns * ppr;
        return (den == 64'd0) ? 64'd0 : 64'd60_000_000_000 / den;
    endfunction

endpackage

// File: rtl/encoder_emulator_if.sv
// RPM command channel: valid/ready handshake carrying an unsigned rpm value.
interface encoder_emulator_if;

    logic [31:0] rpm_in;
    logic        rpm_valid;
    logic        rpm_ready;

    modport master (output rpm_in, output rpm_valid, input  rpm_ready);
    modport slave  (input  rpm_in, input  rpm_valid, output rpm_ready);

endinterface

// File: rtl/div_u32_iter.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// done is high in the cycle whose edge produces the last bit; quotient is final the cycle after.
module div_u32_iter
    import encoder_emu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    logic              busy_q, busy_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [DIV_W-1:0]  rem_q,  rem_d;
    logic [DIV_W-1:0]  quo_q,  quo_d;
    logic [DIV_W-1:0]  dvs_q,  dvs_d;
    logic [DIV_W:0]    rem_shift;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        busy_d    = busy_q;
        iter_d    = iter_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_shift = {rem_q, quo_q[DIV_W-1]};

        if (start) begin
            busy_d = 1'b1;
            iter_d = '0;
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
        end else if (busy_q) begin
            quo_d = {quo_q[DIV_W-2:0], 1'b0};
            if (rem_shift >= {1'b0, dvs_q}) begin
                rem_d    = DIV_W'(rem_shift - {1'b0, dvs_q});
                quo_d[0] = 1'b1;
            end else begin
                rem_d = rem_shift[DIV_W-1:0];
            end
            iter_d = iter_q + 1'b1;
            if (iter_q == ITER_W'(DIV_W - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only.
        if (rst) begin
            busy_q <= 1'b0;
            iter_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            iter_q <= iter_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (iter_q == ITER_W'(DIV_W - 1));
    assign quotient = quo_q;

endmodule

// File: rtl/encoder_emulator.sv
// Encoder pulse generator: an rpm command is divided into a half-period in clocks,
// and data toggles at that rate, picking up new rates only at its own edges.
module encoder_emulator
    import encoder_emu_pkg::*;
#(
    parameter int CLK_PERIOD = 100,
    parameter int PPR        = 10
)
(
    input  logic              clk,
    input  logic              rst,
    encoder_emulator_if.slave cmd,
    output logic              data,
    output logic [31:0]       edge_count,
    output logic              running
);

    localparam logic [63:0]      K_FULL = calc_k(64'(CLK_PERIOD), 64'(PPR));
    localparam logic [DIV_W-1:0] K      = K_FULL[DIV_W-1:0];

    if (CLK_PERIOD < 1 || PPR < 1 || K_FULL < 64'd1 || K_FULL > 64'hFFFF_FFFF) begin : g_k_range
        $error("encoder_emulator: clocks-per-edge constant K out of range [1, 2^32)");
    end

    emu_state_t       state_q, state_d;
    logic             rpm_ready_q, rpm_ready_d;
    logic             accept;
    logic             div_start, div_busy, div_done;
    logic [DIV_W-1:0] div_quotient;
    logic             pend_we;
    logic [31:0]      pend_val;

    assign accept = cmd.rpm_valid && rpm_ready_q;

    div_u32_iter u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (K),
        .divisor  (cmd.rpm_in),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // Controller: accept a command, run the division, publish the half-period.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        pend_we   = 1'b0;
        pend_val  = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd.rpm_in == '0) begin
                        pend_we = 1'b1;
                    end else begin
                        div_start = 1'b1;
                        state_d   = DIV;
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = DONE;
                end else if (!div_busy) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                pend_we  = 1'b1;
                pend_val = (div_quotient == '0) ? 32'd1 : div_quotient;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rpm_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rpm_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rpm_ready_q <= rpm_ready_d;
        end
    end

    assign cmd.rpm_ready = rpm_ready_q;

    logic [31:0] pending_q, pending_d;
    logic [31:0] active_q,  active_d;
    logic [31:0] cnt_q,     cnt_d;
    logic        data_q,    data_d;
    logic [31:0] edge_q,    edge_d;
    logic        running_q, running_d;

    // Generator: active only changes at an edge (or when stopped), so a command never cuts a level short.
    always_comb begin
        pending_d = pend_we ? pend_val : pending_q;
        active_d  = active_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        edge_d    = edge_q;

        if (active_q == '0) begin
            cnt_d    = '0;
            active_d = pending_q;
        end else if (cnt_q == active_q - 32'd1) begin
            data_d   = ~data_q;
            edge_d   = edge_q + 32'd1;
            cnt_d    = '0;
            active_d = pending_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        running_d = (active_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            active_q  <= '0;
            cnt_q     <= '0;
            data_q    <= 1'b0;
            edge_q    <= '0;
            running_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            edge_q    <= edge_d;
            running_q <= running_d;
        end
    end

    assign data       = data_q;
    assign edge_count = edge_q;
    assign running    = running_q;

endmodule

// File: tb/tb_encoder_emulator.sv
// Randomised bench for encoder_emulator: an edge-scheduling reference model feeds a
// scoreboard of expected data edges that a separate monitor checks against the DUT.
module tb_encoder_emulator;

    localparam int CLK_PERIOD = 100;
    localparam int PPR        = 60_000;
    // 60e9 / (100 ns * 60000) clocks per edge
    localparam int unsigned K = 10_000;

    typedef struct {
        int unsigned e;
        logic        level;
        int unsigned cnt;
    } exp_edge_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        data;
    logic [31:0] edge_count;
    logic        running;

    encoder_emulator_if ifc ();

    encoder_emulator #(.CLK_PERIOD(CLK_PERIOD), .PPR(PPR)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (ifc),
        .data       (data),
        .edge_count (edge_count),
        .running    (running)
    );

    always #5 clk = ~clk;

    int unsigned ncmp  = 0;
    int unsigned nfail = 0;

    // Reference model state, advanced once per rising edge.
    int unsigned n        = 0;
    bit          m_level  = 1'b0;
    int unsigned m_edges  = 0;
    int unsigned m_active = 0;
    int unsigned m_next   = 0;
    int unsigned m_pending = 0;
    bit          m_busy   = 1'b0;
    int unsigned m_wr_edge = 0;
    int unsigned m_wr_val  = 0;
    bit          m_rst_now = 1'b0;
    bit          chk_en    = 1'b0;
    exp_edge_t   exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    function automatic int unsigned half_period(input int unsigned rpm);
        int unsigned q;
        q = K / rpm;
        return (q == 0) ? 1 : q;
    endfunction

    // Edge scheduler: next toggle = last toggle + half-period taken from pending at that toggle.
    always @(posedge clk) begin : model
        bit acc;
        n++;
        m_rst_now = rst;
        if (rst) begin
            m_level   = 1'b0;
            m_edges   = 0;
            m_active  = 0;
            m_pending = 0;
            m_busy    = 1'b0;
            exp_q.delete();
            chk_en    = 1'b1;
        end else begin
            acc = ifc.rpm_valid && !m_busy;
            if (m_active == 0) begin
                if (m_pending != 0) begin
                    m_active = m_pending;
                    m_next   = n + m_active;
                end
            end else if (n == m_next) begin
                m_level = !m_level;
                m_edges++;
                exp_q.push_back('{e: n, level: m_level, cnt: m_edges});
                m_active = m_pending;
                if (m_active != 0) m_next = n + m_active;
            end
            if (m_busy && n == m_wr_edge) begin
                m_pending = m_wr_val;
                m_busy    = 1'b0;
            end
            if (acc) begin
                if (ifc.rpm_in == 0) begin
                    m_pending = 0;
                end else begin
                    m_busy    = 1'b1;
                    m_wr_edge = n + 33;
                    m_wr_val  = half_period(ifc.rpm_in);
                end
            end
        end
    end

    // Monitor: pops an expected edge whenever data moves, plus per-cycle output checks.
    logic prev_data = 1'b0;
    always @(negedge clk) begin : monitor
        exp_edge_t x;
        if (chk_en) begin
            while (exp_q.size() > 0 && exp_q[0].e < n) begin
                x = exp_q.pop_front();
                ncmp++;
                nfail++;
                $display("FAIL missing_edge: no data toggle seen, expected one at edge %0d (level %0d)", x.e, x.level);
            end
            if (!m_rst_now && data !== prev_data) begin
                if (exp_q.size() == 0) begin
                    ncmp++;
                    nfail++;
                    $display("FAIL unexpected_edge at edge %0d: data went to %0b, expected no toggle", n, data);
                end else begin
                    x = exp_q.pop_front();
                    check("edge_time", 64'(n), 64'(x.e));
                    check("edge_level", 64'(data), 64'(x.level));
                    check("edge_count_at_edge", 64'(edge_count), 64'(x.cnt));
                end
            end
            check("rpm_ready", 64'(ifc.rpm_ready), 64'(!m_busy));
            check("running", 64'(running), 64'(m_active != 0));
            check("edge_count", 64'(edge_count), 64'(m_edges));
            check("data", 64'(data), 64'(m_level));
        end
        prev_data = data;
    end

    task automatic run(input int unsigned k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v);
        bit          rdy;
        int unsigned k;
        k = 0;
        ifc.rpm_valid = 1'b1;
        ifc.rpm_in    = v;
        forever begin
            @(negedge clk);
            rdy = ifc.rpm_ready;
            @(posedge clk);
            #1;
            k++;
            if (rdy || k >= 200) break;
        end
        if (!rdy) begin
            ncmp++;
            nfail++;
            $display("FAIL accept_timeout: rpm_ready stayed 0 for 200 cycles, expected acceptance of %0d", v);
        end
        ifc.rpm_valid = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned k;
        rst           = 1'b1;
        ifc.rpm_valid = 1'b0;
        ifc.rpm_in    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 100 rpm -> 100 clk levels, then a mid-level change to 200 rpm -> 50
        send(100);
        run(1000);
        run(37);
        send(200);
        run(600);

        // stop at the next scheduled edge, then restart
        send(0);
        run(300);
        send(100);
        run(400);

        // rates at and beyond K clamp to one clock per level
        send(100_000_000);
        run(40);
        send(K);
        run(40);
        send(K + 1);
        run(20);
        send(K - 1);
        run(20);
        send(100);
        run(150);

        // second value held during the division is ignored
        send(250);
        ifc.rpm_valid = 1'b1;
        ifc.rpm_in    = 32'd77;
        run(20);
        ifc.rpm_valid = 1'b0;
        run(200);

        // reset lands in the middle of a division
        send(150);
        run(9);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(100);
        send(100);
        run(300);

        // time the command so its write coincides with a toggle
        k = 0;
        while (!(m_active == 100 && m_next - n == 34) && k < 5000) begin
            run(1);
            k++;
        end
        if (k >= 5000) begin
            ncmp++;
            nfail++;
            $display("FAIL collision_setup: no aligned slot within 5000 cycles, expected one within 100");
        end
        send(200);
        run(400);

        // randomised commands, gaps and held-valid bursts
        for (int i = 0; i < 14; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 9);
            if (kind == 0)      send(0);
            else if (kind == 1) send($urandom_range(32'hFFFF_FFFF, K + 1));
            else                send($urandom_range(100, 2000));
            if ($urandom_range(0, 2) == 0) begin
                ifc.rpm_valid = 1'b1;
                ifc.rpm_in    = $urandom_range(100, 2000);
                run($urandom_range(1, 40));
                ifc.rpm_valid = 1'b0;
            end
            run($urandom_range(0, 250));
        end

        run(300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
